// File: rtl/path_loader.sv
// Runtime-loaded navigation path table with registered prev/cur/next lookup.
// Optional macro PATH_RANGE_CHECK_EN rejects node IDs >= NODES during load.
module path_loader #(
  parameter int DEPTH = 32,
  parameter int NODES = 30
) (
  input  logic       clk_3125k,
  input  logic       rst,
  input  logic       wr_start,
  input  logic       wr_valid,
  input  logic [4:0] wr_node,
  input  logic       wr_last,
  output logic       wr_ready,
  input  logic [7:0] node_count,
  output logic [4:0] node_state,
  output logic [4:0] previous_node,
  output logic [4:0] next_node,
  output logic [5:0] path_len,
  output logic       path_ready,
  output logic       path_err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LOAD = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;
  localparam logic [1:0] S_ERR  = 2'd3;

  localparam logic [4:0] NONE     = 5'd31;
  localparam logic [4:0] NODE_LIM = 5'(NODES);
  localparam logic [5:0] LAST_IDX = 6'(DEPTH - 1);

`ifdef PATH_RANGE_CHECK_EN
  localparam bit RANGE_CHK = 1'b1;
`else
  localparam bit RANGE_CHK = 1'b0;
`endif

  logic [1:0] state_q, state_d;
  logic [5:0] len_q, len_d;
  logic [4:0] mem_q [0:DEPTH-1];
  logic       we;
  logic       bad_node;

  logic [4:0] prev_q, prev_d;
  logic [4:0] cur_q, cur_d;
  logic [4:0] next_q, next_d;

  logic [7:0] len8;
  logic [8:0] len9;
  logic [8:0] nc_p1;
  logic [4:0] idx;

  always_comb begin
    state_d  = state_q;
    len_d    = len_q;
    we       = 1'b0;
    bad_node = RANGE_CHK && (wr_node >= NODE_LIM);
    if (wr_start) begin
      state_d = S_LOAD;
      len_d   = '0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (wr_valid) begin
            if (bad_node) begin
              state_d = S_ERR;
            end else begin
              we    = 1'b1;
              len_d = len_q + 6'd1;
              if (wr_last)
                state_d = S_DONE;
              else if (len_q == LAST_IDX)
                state_d = S_ERR;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Lookup is evaluated against the current table and registered once.
  always_comb begin
    len8   = {2'b00, len_q};
    len9   = {3'b000, len_q};
    nc_p1  = {1'b0, node_count} + 9'd1;
    idx    = node_count[4:0];
    prev_d = NONE;
    cur_d  = NONE;
    next_d = NONE;
    if (state_q == S_DONE && node_count < len8) begin
      cur_d = mem_q[idx];
      if (node_count != 8'd0)
        prev_d = mem_q[idx - 5'd1];
      if (nc_p1 < len9)
        next_d = mem_q[idx + 5'd1];
    end
  end

  always_ff @(posedge clk_3125k) begin
    if (rst) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      prev_q  <= NONE;
      cur_q   <= NONE;
      next_q  <= NONE;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      prev_q  <= prev_d;
      cur_q   <= cur_d;
      next_q  <= next_d;
    end
  end

  always_ff @(posedge clk_3125k) begin
    if (we)
      mem_q[len_q[4:0]] <= wr_node;
  end

  assign wr_ready      = (state_q == S_LOAD);
  assign path_ready    = (state_q == S_DONE);
  assign path_err      = (state_q == S_ERR);
  assign path_len      = len_q;
  assign node_state    = cur_q;
  assign previous_node = prev_q;
  assign next_node     = next_q;

endmodule
